// File: rtl/bounded_counter.sv
// bounded_counter: up/down counter with runtime step, programmable inclusive
// bounds, four boundary modes (wrap, saturate, bounce, free-run) and an
// enable prescaler so slow game logic can run from the fast system clock.
module bounded_counter #(
    parameter int WIDTH  = 10,
    parameter int STEP_W = 4,
    parameter int DIV    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  D,
    input  logic              up,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  low,
    input  logic [WIDTH-1:0]  high,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  Q,
    output logic              dir,
    output logic              tc,
    output logic              at_low,
    output logic              at_high
);

    // Prescaler width; DIV=1 still keeps a 1-bit counter that never leaves 0.
    localparam int            PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);

    localparam logic [1:0] MODE_WRAP   = 2'b00;
    localparam logic [1:0] MODE_SAT    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_FREE   = 2'b11;

    logic [WIDTH-1:0] r_q;
    logic             r_dir;
    logic             r_tc;
    logic [PW-1:0]    r_pcount;

    logic             w_tick;
    logic [WIDTH:0]   w_step_x;
    logic [WIDTH:0]   w_low_x;
    logic [WIDTH:0]   w_high_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_borrow;
    logic [WIDTH-1:0] w_q_nx;
    logic             w_dir_nx;
    logic             w_tc_nx;

    // Sums carry one extra bit so overflow and borrow are visible directly.
    assign w_step_x = (WIDTH + 1)'(step);
    assign w_low_x  = {1'b0, low};
    assign w_high_x = {1'b0, high};
    assign w_sum    = {1'b0, r_q} + w_step_x;
    assign w_diff   = {1'b0, r_q} - w_step_x;
    assign w_borrow = w_diff[WIDTH];

    assign w_tick  = en & (r_pcount == P_LAST);

    assign Q       = r_q;
    assign tc      = r_tc;
    assign dir     = (mode == MODE_BOUNCE) ? r_dir : up;
    assign at_low  = (r_q == low);
    assign at_high = (r_q == high);

    // Next count, direction and terminal-count for an advancing cycle.
    always_comb begin
        w_q_nx   = r_q;
        w_dir_nx = r_dir;
        w_tc_nx  = 1'b0;
        case (mode)
            MODE_WRAP: begin
                if (up) begin
                    if (w_sum > w_high_x) begin
                        w_q_nx  = low;
                        w_tc_nx = 1'b1;
                    end else begin
                        w_q_nx = w_sum[WIDTH-1:0];
                    end
                end else begin
                    if (w_borrow || (w_diff < w_low_x)) begin
                        w_q_nx  = high;
                        w_tc_nx = 1'b1;
                    end else begin
                        w_q_nx = w_diff[WIDTH-1:0];
                    end
                end
            end
            MODE_SAT: begin
                if (up) begin
                    if (w_sum > w_high_x) begin
                        w_q_nx = high;
                    end else if (w_sum < w_low_x) begin
                        w_q_nx = low;
                    end else begin
                        w_q_nx = w_sum[WIDTH-1:0];
                    end
                    w_tc_nx = (w_q_nx == high) && (r_q != high);
                end else begin
                    if (w_borrow || (w_diff < w_low_x)) begin
                        w_q_nx = low;
                    end else if (w_diff > w_high_x) begin
                        w_q_nx = high;
                    end else begin
                        w_q_nx = w_diff[WIDTH-1:0];
                    end
                    w_tc_nx = (w_q_nx == low) && (r_q != low);
                end
            end
            MODE_BOUNCE: begin
                if (r_dir) begin
                    if (w_sum >= w_high_x) begin
                        w_q_nx   = high;
                        w_dir_nx = 1'b0;
                        w_tc_nx  = 1'b1;
                    end else begin
                        w_q_nx = w_sum[WIDTH-1:0];
                    end
                end else begin
                    if (w_borrow || (w_diff <= w_low_x)) begin
                        w_q_nx   = low;
                        w_dir_nx = 1'b1;
                        w_tc_nx  = 1'b1;
                    end else begin
                        w_q_nx = w_diff[WIDTH-1:0];
                    end
                end
            end
            MODE_FREE: begin
                if (up) begin
                    w_q_nx  = w_sum[WIDTH-1:0];
                    w_tc_nx = w_sum[WIDTH];
                end else begin
                    w_q_nx  = w_diff[WIDTH-1:0];
                    w_tc_nx = w_borrow;
                end
            end
            default: begin
                w_q_nx   = r_q;
                w_dir_nx = r_dir;
                w_tc_nx  = 1'b0;
            end
        endcase
    end

    // State update: reset > clr > load > prescaled advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= {WIDTH{1'b0}};
            r_dir    <= 1'b1;
            r_tc     <= 1'b0;
            r_pcount <= {PW{1'b0}};
        end else if (clr) begin
            r_q      <= low;
            r_dir    <= 1'b1;
            r_tc     <= 1'b0;
            r_pcount <= {PW{1'b0}};
        end else if (load) begin
            r_q      <= D;
            r_tc     <= 1'b0;
            r_pcount <= {PW{1'b0}};
        end else if (w_tick) begin
            r_q      <= w_q_nx;
            r_dir    <= w_dir_nx;
            r_tc     <= w_tc_nx;
            r_pcount <= {PW{1'b0}};
        end else if (en) begin
            r_tc     <= 1'b0;
            r_pcount <= r_pcount + PW'(1);
        end else begin
            r_tc     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bounded_counter.sv
// Scoreboard bench for bounded_counter: the stimulus process pushes the
// hand-computed expected state for each clock edge, and a separate monitor
// pops and compares just after every rising edge. Two instances share the
// inputs: dut (DIV=1) and dut_p (DIV=4) for prescaler behaviour.
module tb_bounded_counter;

    logic       clk = 1'b0;
    logic       reset, en, clr, load, up;
    logic [9:0] D, low, high;
    logic [3:0] step;
    logic [1:0] mode;

    logic [9:0] q, qp;
    logic       dir, tc, at_low, at_high;
    logic       dirp, tcp, at_lowp, at_highp;

    typedef struct {
        bit         cm;
        logic [9:0] q;
        logic       tc;
        logic       dir;
        logic       al;
        logic       ah;
        bit         cp;
        logic [9:0] qp;
        logic       tcp;
        int         idx;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_push = 0;

    always #5 clk = ~clk;

    bounded_counter #(.WIDTH(10), .STEP_W(4), .DIV(1)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .D(D),
        .up(up), .step(step), .low(low), .high(high), .mode(mode),
        .Q(q), .dir(dir), .tc(tc), .at_low(at_low), .at_high(at_high)
    );

    bounded_counter #(.WIDTH(10), .STEP_W(4), .DIV(4)) dut_p (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .D(D),
        .up(up), .step(step), .low(low), .high(high), .mode(mode),
        .Q(qp), .dir(dirp), .tc(tcp), .at_low(at_lowp), .at_high(at_highp)
    );

    task automatic cmp(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    // Push expectation for the coming edge, then move to the next falling edge.
    task automatic chk(input bit cm, input logic [9:0] eq, input logic etc, input logic edir,
                       input bit cp, input logic [9:0] eqp, input logic etcp);
        exp_t e;
        e.cm  = cm;
        e.q   = eq;
        e.tc  = etc;
        e.dir = edir;
        e.al  = (eq == low);
        e.ah  = (eq == high);
        e.cp  = cp;
        e.qp  = eqp;
        e.tcp = etcp;
        e.idx = n_push;
        n_push++;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic m(input logic [9:0] eq, input logic etc, input logic edir);
        chk(1'b1, eq, etc, edir, 1'b0, 10'd0, 1'b0);
    endtask

    task automatic p(input logic [9:0] eqp, input logic etcp);
        chk(1'b0, 10'd0, 1'b0, 1'b0, 1'b1, eqp, etcp);
    endtask

    // Monitor: compare after every rising edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.cm) begin
                    cmp("Q",       e.idx, 32'(q),       32'(e.q));
                    cmp("tc",      e.idx, 32'(tc),      32'(e.tc));
                    cmp("dir",     e.idx, 32'(dir),     32'(e.dir));
                    cmp("at_low",  e.idx, 32'(at_low),  32'(e.al));
                    cmp("at_high", e.idx, 32'(at_high), 32'(e.ah));
                end
                if (e.cp) begin
                    cmp("Qp",  e.idx, 32'(qp),  32'(e.qp));
                    cmp("tcp", e.idx, 32'(tcp), 32'(e.tcp));
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0; D = 10'd0; up = 1'b1;
        step = 4'd0; low = 10'd0; high = 10'd0; mode = 2'b00;
        chk(1'b1, 10'd0, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0);

        // Bounce between 10 and 20 with step 4
        reset = 1'b0; mode = 2'b10; low = 10'd10; high = 10'd20; step = 4'd4;
        load = 1'b1; D = 10'd10; en = 1'b1;
        m(10'd10, 1'b0, 1'b1);
        load = 1'b0;
        m(10'd14, 1'b0, 1'b1);
        m(10'd18, 1'b0, 1'b1);
        m(10'd20, 1'b1, 1'b0);
        m(10'd16, 1'b0, 1'b0);
        m(10'd12, 1'b0, 1'b0);
        m(10'd10, 1'b1, 1'b1);
        m(10'd14, 1'b0, 1'b1);

        // Wrap 0..9 step 3
        mode = 2'b00; low = 10'd0; high = 10'd9; step = 4'd3; up = 1'b1; clr = 1'b1;
        m(10'd0, 1'b0, 1'b1);
        clr = 1'b0;
        m(10'd3, 1'b0, 1'b1);
        m(10'd6, 1'b0, 1'b1);
        m(10'd9, 1'b0, 1'b1);
        m(10'd0, 1'b1, 1'b1);
        load = 1'b1; D = 10'd2; up = 1'b0;
        m(10'd2, 1'b0, 1'b0);
        load = 1'b0;
        m(10'd9, 1'b1, 1'b0);

        // Saturate 5..8 step 2
        mode = 2'b01; low = 10'd5; high = 10'd8; step = 4'd2; up = 1'b1;
        load = 1'b1; D = 10'd5;
        m(10'd5, 1'b0, 1'b1);
        load = 1'b0;
        m(10'd7, 1'b0, 1'b1);
        m(10'd8, 1'b1, 1'b1);
        m(10'd8, 1'b0, 1'b1);
        up = 1'b0;
        m(10'd6, 1'b0, 1'b0);
        m(10'd5, 1'b1, 1'b0);
        m(10'd5, 1'b0, 1'b0);

        // Free-run carry and borrow
        mode = 2'b11; step = 4'd3; up = 1'b1; load = 1'b1; D = 10'd1022;
        m(10'd1022, 1'b0, 1'b1);
        load = 1'b0;
        m(10'd1, 1'b1, 1'b1);
        up = 1'b0;
        m(10'd1022, 1'b1, 1'b0);

        // Priority: clr beats load and tick, restores dir_q
        mode = 2'b10; low = 10'd10; high = 10'd20; step = 4'd4; load = 1'b1; D = 10'd18;
        m(10'd18, 1'b0, 1'b1);
        load = 1'b0;
        m(10'd20, 1'b1, 1'b0);
        clr = 1'b1; load = 1'b1; D = 10'd15;
        m(10'd10, 1'b0, 1'b1);
        clr = 1'b0; load = 1'b0;

        // Prescaler DIV=4, with a 2-cycle en gap mid-interval
        mode = 2'b11; step = 4'd1; up = 1'b1; load = 1'b1; D = 10'd0;
        chk(1'b1, 10'd0, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        load = 1'b0;
        p(10'd0, 1'b0);
        p(10'd0, 1'b0);
        p(10'd0, 1'b0);
        p(10'd1, 1'b0);
        p(10'd1, 1'b0);
        en = 1'b0;
        p(10'd1, 1'b0);
        p(10'd1, 1'b0);
        en = 1'b1;
        p(10'd1, 1'b0);
        p(10'd1, 1'b0);
        p(10'd2, 1'b0);

        // Reset mid-bounce while moving down
        mode = 2'b10; low = 10'd10; high = 10'd20; step = 4'd4; load = 1'b1; D = 10'd18;
        m(10'd18, 1'b0, 1'b1);
        load = 1'b0;
        m(10'd20, 1'b1, 1'b0);
        reset = 1'b1;
        chk(1'b1, 10'd0, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        reset = 1'b0;
        chk(1'b1, 10'd4,  1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        chk(1'b1, 10'd8,  1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        chk(1'b1, 10'd12, 1'b0, 1'b1, 1'b1, 10'd0, 1'b0);
        chk(1'b1, 10'd16, 1'b0, 1'b1, 1'b1, 10'd4, 1'b0);

        // Bounded drain of the scoreboard
        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
